seq_detect_n: RTL and testbench
===============================

# seq_detect_n

Parametrised Moore sequence detector for a single-bit serial stream with a per-cycle valid qualifier. It matches a programmable pattern of 1–8 bits, MSB first. It raises `out` while the full pattern has been seen and keeps a saturating match count. It sits directly behind serial sampling logic and generalises the two-state level-tracking FSM to an (LEN+1)-state pattern matcher with a stall input and a statistics counter.

## Interface
- LEN, 4, pattern length in bits; legal range 1–8
- PATTERN, 8'b0000_1011, pattern bits; only bits [LEN-1:0] are used; bit LEN-1 is matched first
- CNT_W, 8, width of match counter
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  `a` is accepted on this edge when high
- a  in  1  serial data bit
- clr_cnt  in  1  synchronous clear of match_cnt
- out  out  1  Moore output, high iff state == LEN
- state  out  4  current state (matched-prefix length 0..LEN), debug
- match_cnt  out  CNT_W  number of completed matches, saturating

## Operation
- State k (0..LEN): the last k accepted bits equal PATTERN[LEN-1 -: k]. There are LEN+1 states, S0..S_LEN.
- Bits are accepted only when in_valid=1. When in_valid=0, state, out and match_cnt hold.
- Next state from S_k (k<LEN) on accepted bit b:
  - History H is PATTERN[LEN-1 -: k] followed by b.
  - The next state is the largest j ≤ k+1 such that the last j bits of H equal PATTERN[LEN-1 -: j]. This is KMP-style fallback and is computed from parameters only.
  - If no such j ≥ 1 exists, the next state is 0.
- From S_LEN on accepted bit b: mode-dependent, see Configuration.
- out = (state == LEN). It is a pure function of the registered state, with no combinational path from `a`.
- match_cnt increments by 1 on every transition into S_LEN, including a self-loop S_LEN→S_LEN in overlap mode.
  - match_cnt saturates at 2^CNT_W−1.
  - clr_cnt=1 forces match_cnt to 0 on that edge and has priority over a simultaneous increment.
- rst=1: state←0, out←0, match_cnt←0. rst has priority over in_valid and clr_cnt.
- Reset mid-pattern discards the partial match. The first accepted bit after rst deasserts is treated as pattern bit LEN-1.
- LEN=1: S0/S1 only. out follows the last accepted bit compared against PATTERN[0].
- Unused state encodings (LEN+1..15) go to S0 on the next edge regardless of in_valid.

## Timing
- Reset values: out=0, state=0, match_cnt=0.
- Latency: if the final pattern bit is accepted on edge t, out=1 and match_cnt is updated after edge t. Both are visible in the cycle following t.
- out stays high until the next accepted bit moves the state out of S_LEN. With in_valid=0, out stays high indefinitely.
- One accepted bit per cycle at most. Back-to-back in_valid gives full throughput.
- clr_cnt takes effect on the edge it is sampled, independent of in_valid.

## Configuration
- Macro: SEQ_DETECT_N_OVERLAP_EN.
- Defined (overlap mode): from S_LEN, history is the full PATTERN followed by b. The next state is the largest j ≤ LEN with a suffix/prefix match, so matches may share bits.
- Undefined (non-overlap mode): from S_LEN, the accepted bit is evaluated as if from S0, so a new match needs LEN fresh bits. For LEN=4, PATTERN=1011 and b=1, the next state is S1.

## Test plan
- Basic match: LEN=4, PATTERN=1011, in_valid=1, stream 1,0,1,1 → out=1 in the cycle after the 4th edge, state=4, match_cnt=1.
- Overlap: stream 1,0,1,1,0,1,1 → with SEQ_DETECT_N_OVERLAP_EN, match_cnt=2 and out high after bits 4 and 7. Without it, match_cnt=1 and out is high only after bit 4.
- Fallback: stream 1,1,0,1,1 → states 1,1,2,3,4; match on bit 5, match_cnt=1.
- Stall: stream 1,0 then in_valid=0 for 5 cycles with a toggling, then 1,1 → state holds at 2 during the stall; match after the 4th accepted bit.
- Reset mid-pattern: stream 1,0,1, assert rst one cycle, then 1 → state=1 after that edge, out=0, match_cnt=0. Sync reset is sampled only at the clock edge.
- Counter: CNT_W=2, 5 matches → match_cnt saturates at 3. clr_cnt coincident with a 6th match → match_cnt=0, out=1.

Source files
------------

// File: rtl/seq_detect_n_if.sv
// Bundles the serial-stream side of seq_detect_n: qualified data bit in, match status out.
// Latency: none (wiring only).
// Backpressure: none; the producer qualifies each bit with in_valid and never stalls.
interface seq_detect_n_if #(
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             a;
    logic             clr_cnt;
    logic             out;
    logic [3:0]       state;
    logic [CNT_W-1:0] match_cnt;

    // Stream source / monitor side
    modport master (
        output in_valid, a, clr_cnt,
        input  out, state, match_cnt
    );

    // Detector side
    modport slave (
        input  in_valid, a, clr_cnt,
        output out, state, match_cnt
    );
endinterface

// File: rtl/seq_detect_n.sv
// Moore detector for a 1..8 bit MSB-first pattern on a valid-qualified serial stream, with saturating match counter.
// Latency: out and match_cnt update on the edge that accepts the final pattern bit (visible the following cycle).
// Backpressure: none; in_valid=0 stalls the matcher. Macro SEQ_DETECT_N_OVERLAP_EN lets consecutive matches share bits.
module seq_detect_n #(
    parameter int         LEN     = 4,
    parameter logic [7:0] PATTERN = 8'b0000_1011,
    parameter int         CNT_W   = 8
) (
    input logic         clk,
    input logic         rst,
    seq_detect_n_if.slave bus
);
    typedef enum logic [3:0] {S0, S1, S2, S3, S4, S5, S6, S7, S8} state_t;

    localparam logic [3:0]       LAST    = 4'(LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Longest pattern prefix that is a suffix of (PATTERN[LEN-1 -: k], b), capped at LEN.
    // Evaluated only with constant arguments, so it folds into a lookup table.
    function automatic logic [3:0] f_next(input int k, input logic b);
        logic [7:0] p;
        logic [3:0] res;
        logic       ok;
        logic       hb;
        int         jmax;
        int         idx;
        p    = PATTERN;
        res  = 4'd0;
        jmax = (k + 1 > LEN) ? LEN : k + 1;
        for (int j = 1; j <= 8; j++) begin
            if (j <= jmax) begin
                ok = 1'b1;
                for (int m = 0; m < 8; m++) begin
                    if (m < j) begin
                        idx = k + 1 - j + m;
                        hb  = (idx < k) ? p[3'(LEN - 1 - idx)] : b;
                        if (hb != p[3'(LEN - 1 - m)]) ok = 1'b0;
                    end
                end
                if (ok) res = 4'(j);
            end
        end
        return res;
    endfunction

    state_t           r_state;
    state_t           w_nxt_state;
    logic             w_hit;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       w_tbl0 [16];
    logic [3:0]       w_tbl1 [16];

    // Transition table for a 0 / 1 bit from every encoding; illegal encodings map to S0.
    for (genvar k = 0; k < 16; k++) begin : g_tbl
        if (k < LEN) begin : g_prefix
            assign w_tbl0[k] = f_next(k, 1'b0);
            assign w_tbl1[k] = f_next(k, 1'b1);
        end else if (k == LEN) begin : g_full
`ifdef SEQ_DETECT_N_OVERLAP_EN
            assign w_tbl0[k] = f_next(LEN, 1'b0);
            assign w_tbl1[k] = f_next(LEN, 1'b1);
`else
            // A fresh match needs LEN new bits: restart as if from S0.
            assign w_tbl0[k] = f_next(0, 1'b0);
            assign w_tbl1[k] = f_next(0, 1'b1);
`endif
        end else begin : g_unused
            assign w_tbl0[k] = 4'd0;
            assign w_tbl1[k] = 4'd0;
        end
    end

    // State register: matched-prefix length.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S0;
        else     r_state <= w_nxt_state;
    end

    // Next state: hold when stalled, table lookup on an accepted bit, recover from illegal codes unconditionally.
    always_comb begin
        w_nxt_state = r_state;
        w_hit       = 1'b0;
        if (r_state > LAST) begin
            w_nxt_state = S0;
        end else if (bus.in_valid) begin
            w_nxt_state = state_t'(bus.a ? w_tbl1[r_state] : w_tbl0[r_state]);
            w_hit       = (w_nxt_state == LAST);
        end
    end

    // Match counter: clear wins over increment, saturates at all-ones.
    always_ff @(posedge clk) begin
        if (rst)                           r_cnt <= '0;
        else if (bus.clr_cnt)              r_cnt <= '0;
        else if (w_hit && r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
    end

    assign bus.out       = (r_state == LAST);
    assign bus.state     = r_state;
    assign bus.match_cnt = r_cnt;
endmodule

// File: tb/tb_seq_detect_n.sv
// Directed bench for seq_detect_n (LEN=4, PATTERN=1011): table of per-edge vectors plus counter saturation sequence.
// Latency: checks sample 1 ns after each rising edge.
// Backpressure: n/a; stalls are driven through in_valid.
module tb_seq_detect_n;
`ifdef SEQ_DETECT_N_OVERLAP_EN
    localparam bit OV = 1'b1;
`else
    localparam bit OV = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, in_valid, a, clr_cnt;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    seq_detect_n_if #(.CNT_W(8)) if_a ();
    seq_detect_n_if #(.CNT_W(2)) if_c ();

    assign if_a.in_valid = in_valid;
    assign if_a.a        = a;
    assign if_a.clr_cnt  = clr_cnt;
    assign if_c.in_valid = in_valid;
    assign if_c.a        = a;
    assign if_c.clr_cnt  = clr_cnt;

    seq_detect_n #(.LEN(4), .PATTERN(8'b0000_1011), .CNT_W(8)) u_a (.clk(clk), .rst(rst), .bus(if_a));
    seq_detect_n #(.LEN(4), .PATTERN(8'b0000_1011), .CNT_W(2)) u_c (.clk(clk), .rst(rst), .bus(if_c));

    typedef struct {
        logic       rst;
        logic       vld;
        logic       a;
        logic       clr;
        logic [3:0] exp_state;
        logic       exp_out;
        logic [7:0] exp_cnt;
    } vec_t;

    vec_t tbl [31];

    function automatic vec_t mk(input logic r, input logic v, input logic b, input logic c,
                                input int st, input logic o, input int cn);
        vec_t t;
        t.rst = r; t.vld = v; t.a = b; t.clr = c;
        t.exp_state = 4'(st); t.exp_out = o; t.exp_cnt = 8'(cn);
        return t;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic apply(input logic r, input logic v, input logic b, input logic c);
        rst = r; in_valid = v; a = b; clr_cnt = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = 1'b0; clr_cnt = 1'b0;

        // reset, basic match, stall at S4, overlap-dependent continuation
        tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 1, 1, 0, 1, 0, 0);
        tbl[2]  = mk(0, 1, 0, 0, 2, 0, 0);
        tbl[3]  = mk(0, 1, 1, 0, 3, 0, 0);
        tbl[4]  = mk(0, 1, 1, 0, 4, 1, 1);
        tbl[5]  = mk(0, 0, 0, 0, 4, 1, 1);
        tbl[6]  = mk(0, 1, 0, 0, OV ? 2 : 0, 0, 1);
        tbl[7]  = mk(0, 1, 1, 0, OV ? 3 : 1, 0, 1);
        tbl[8]  = mk(0, 1, 1, 0, OV ? 4 : 1, OV, OV ? 2 : 1);
        // fallback 1,1,0,1,1
        tbl[9]  = mk(1, 0, 0, 0, 0, 0, 0);
        tbl[10] = mk(0, 1, 1, 0, 1, 0, 0);
        tbl[11] = mk(0, 1, 1, 0, 1, 0, 0);
        tbl[12] = mk(0, 1, 0, 0, 2, 0, 0);
        tbl[13] = mk(0, 1, 1, 0, 3, 0, 0);
        tbl[14] = mk(0, 1, 1, 0, 4, 1, 1);
        // stall mid-pattern with a toggling
        tbl[15] = mk(1, 0, 0, 0, 0, 0, 0);
        tbl[16] = mk(0, 1, 1, 0, 1, 0, 0);
        tbl[17] = mk(0, 1, 0, 0, 2, 0, 0);
        tbl[18] = mk(0, 0, 1, 0, 2, 0, 0);
        tbl[19] = mk(0, 0, 0, 0, 2, 0, 0);
        tbl[20] = mk(0, 0, 1, 0, 2, 0, 0);
        tbl[21] = mk(0, 0, 0, 0, 2, 0, 0);
        tbl[22] = mk(0, 0, 1, 0, 2, 0, 0);
        tbl[23] = mk(0, 1, 1, 0, 3, 0, 0);
        tbl[24] = mk(0, 1, 1, 0, 4, 1, 1);
        // clear without valid; out holds
        tbl[25] = mk(0, 0, 0, 1, 4, 1, 0);
        // from S4 with 1 -> S1 in both modes; then reset mid-pattern with valid high
        tbl[26] = mk(0, 1, 1, 0, 1, 0, 0);
        tbl[27] = mk(0, 1, 0, 0, 2, 0, 0);
        tbl[28] = mk(0, 1, 1, 0, 3, 0, 0);
        tbl[29] = mk(1, 1, 1, 0, 0, 0, 0);
        tbl[30] = mk(0, 1, 1, 0, 1, 0, 0);

        for (int i = 0; i < 31; i++) begin
            apply(tbl[i].rst, tbl[i].vld, tbl[i].a, tbl[i].clr);
            chk($sformatf("row%0d state", i), int'(if_a.state), int'(tbl[i].exp_state));
            chk($sformatf("row%0d out", i), int'(if_a.out), int'(tbl[i].exp_out));
            chk($sformatf("row%0d match_cnt", i), int'(if_a.match_cnt), int'(tbl[i].exp_cnt));
        end

        // counter saturation on the 2-bit instance: five back-to-back 1011 matches
        apply(1, 0, 0, 0);
        chk("sat reset cnt", int'(if_c.match_cnt), 0);
        for (int n = 1; n <= 5; n++) begin
            apply(0, 1, 1, 0);
            apply(0, 1, 0, 0);
            apply(0, 1, 1, 0);
            apply(0, 1, 1, 0);
            chk($sformatf("sat match%0d cnt_w2", n), int'(if_c.match_cnt), (n > 3) ? 3 : n);
            chk($sformatf("sat match%0d cnt_w8", n), int'(if_a.match_cnt), n);
            chk($sformatf("sat match%0d out", n), int'(if_c.out), 1);
        end
        // sixth match with clr_cnt on the completing edge: clear wins, out still rises
        apply(0, 1, 1, 0);
        apply(0, 1, 0, 0);
        apply(0, 1, 1, 0);
        apply(0, 1, 1, 1);
        chk("clr vs hit cnt_w2", int'(if_c.match_cnt), 0);
        chk("clr vs hit cnt_w8", int'(if_a.match_cnt), 0);
        chk("clr vs hit out", int'(if_c.out), 1);
        chk("clr vs hit state", int'(if_c.state), 4);
        apply(0, 0, 0, 0);
        chk("post clr out hold", int'(if_c.out), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
